// File: rtl/sevenseg_scan_driver.sv
// Seven-segment scan driver for the two 4-digit multiplexed displays (A, B).
// Register values are held in a shadow copy that reloads only at frame end,
// and each digit slot starts with a blanking guard to suppress ghosting.
// Optional feature: define SEVENSEG_BRIGHTNESS_EN to add a brightness[3:0]
// input that shortens the lit window within each slot.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   PH_BLANK | slot guard, all grids off
//   PH_ON    | selected digit driven
//   PH_DARK  | past the brightness window, behaves like PH_BLANK
module sevenseg_scan_driver #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    input  logic        update_req,
`ifdef SEVENSEG_BRIGHTNESS_EN
    input  logic [3:0]  brightness,
`endif
    output logic        update_ack,
    output logic        frame_start,
    output logic [7:0]  hex_segA,
    output logic [3:0]  hex_gridA,
    output logic [7:0]  hex_segB,
    output logic [3:0]  hex_gridB
);

    localparam int CW = $clog2(CLK_DIV);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t        SLOT_LAST = cnt_t'(CLK_DIV - 1);
    localparam logic [31:0] BLANK_U   = 32'(BLANK_CYCLES);
    localparam logic [31:0] SPAN_U    = 32'(CLK_DIV - BLANK_CYCLES);

    typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_DARK} phase_t;

    function automatic logic [6:0] hexenc(input logic [3:0] n);
        case (n)
            4'h0: hexenc = 7'h3F;  4'h1: hexenc = 7'h06;
            4'h2: hexenc = 7'h5B;  4'h3: hexenc = 7'h4F;
            4'h4: hexenc = 7'h66;  4'h5: hexenc = 7'h6D;
            4'h6: hexenc = 7'h7D;  4'h7: hexenc = 7'h07;
            4'h8: hexenc = 7'h7F;  4'h9: hexenc = 7'h6F;
            4'hA: hexenc = 7'h77;  4'hB: hexenc = 7'h7C;
            4'hC: hexenc = 7'h39;  4'hD: hexenc = 7'h5E;
            4'hE: hexenc = 7'h79;  default: hexenc = 7'h71;
        endcase
    endfunction

    cnt_t        slot_cnt_q, slot_cnt_d;
    logic [1:0]  scan_idx_q, scan_idx_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  dp_q, dp_d, en_q, en_d;
    logic        load_pend_q, load_pend_d;
    logic        ack_q, ack_d, fs_q, fs_d;
    logic [7:0]  seg_a_q, seg_a_d, seg_b_q, seg_b_d;
    logic [3:0]  grid_a_q, grid_a_d, grid_b_q, grid_b_d;
    phase_t      phase_q, phase_d;
    logic        frame_last, load;
    logic [31:0] win_w, slot_nx;
`ifdef SEVENSEG_BRIGHTNESS_EN
    logic [3:0]  bright_q, bright_d;
`endif

    // Slot/scan counters, shadow reload at frame end, handshake pulses.
    always_comb begin
        frame_last  = (scan_idx_q == 2'd3) && (slot_cnt_q == SLOT_LAST);
        load        = frame_last && update_req;
        slot_cnt_d  = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + cnt_t'(1);
        scan_idx_d  = (slot_cnt_q == SLOT_LAST) ? scan_idx_q + 2'd1 : scan_idx_q;
        data_d      = load ? data_in : data_q;
        dp_d        = load ? dp_in   : dp_q;
        en_d        = load ? en_in   : en_q;
`ifdef SEVENSEG_BRIGHTNESS_EN
        bright_d    = load ? brightness : bright_q;
`endif
        // Ack is delayed one stage so it lines up with frame_start, which
        // like every output appears one cycle after the counter state (0,0).
        load_pend_d = load;
        ack_d       = load_pend_q;
        fs_d        = (slot_cnt_q == '0) && (scan_idx_q == 2'd0);
    end

    // Next slot phase, decoded from the counter value of the coming cycle.
    always_comb begin
`ifdef SEVENSEG_BRIGHTNESS_EN
        win_w = (SPAN_U * (32'(bright_d) + 32'd1)) >> 4;
`else
        win_w = SPAN_U;
`endif
        slot_nx = 32'(slot_cnt_d);
        phase_d = PH_DARK;
        if (slot_nx < BLANK_U)
            phase_d = PH_BLANK;
        else if (slot_nx < BLANK_U + win_w)
            phase_d = PH_ON;
    end

    // Segment/grid decode for the digit currently selected on both displays.
    always_comb begin
        seg_a_d  = 8'hFF;
        grid_a_d = 4'hF;
        seg_b_d  = 8'hFF;
        grid_b_d = 4'hF;
        if (phase_q == PH_ON) begin
            if (en_q[{1'b0, scan_idx_q}]) begin
                grid_a_d = ~(4'b0001 << scan_idx_q);
                seg_a_d  = ~{dp_q[{1'b0, scan_idx_q}],
                             hexenc(data_q[4*int'(scan_idx_q) +: 4])};
            end
            if (en_q[{1'b1, scan_idx_q}]) begin
                grid_b_d = ~(4'b0001 << scan_idx_q);
                seg_b_d  = ~{dp_q[{1'b1, scan_idx_q}],
                             hexenc(data_q[16 + 4*int'(scan_idx_q) +: 4])};
            end
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt_q  <= '0;
            scan_idx_q  <= 2'd0;
            data_q      <= '0;
            dp_q        <= '0;
            en_q        <= '0;
            load_pend_q <= 1'b0;
            ack_q       <= 1'b0;
            fs_q        <= 1'b0;
            phase_q     <= PH_BLANK;
            seg_a_q     <= 8'hFF;
            grid_a_q    <= 4'hF;
            seg_b_q     <= 8'hFF;
            grid_b_q    <= 4'hF;
`ifdef SEVENSEG_BRIGHTNESS_EN
            bright_q    <= '0;
`endif
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            scan_idx_q  <= scan_idx_d;
            data_q      <= data_d;
            dp_q        <= dp_d;
            en_q        <= en_d;
            load_pend_q <= load_pend_d;
            ack_q       <= ack_d;
            fs_q        <= fs_d;
            phase_q     <= phase_d;
            seg_a_q     <= seg_a_d;
            grid_a_q    <= grid_a_d;
            seg_b_q     <= seg_b_d;
            grid_b_q    <= grid_b_d;
`ifdef SEVENSEG_BRIGHTNESS_EN
            bright_q    <= bright_d;
`endif
        end
    end

    assign update_ack  = ack_q;
    assign frame_start = fs_q;
    assign hex_segA    = seg_a_q;
    assign hex_gridA   = grid_a_q;
    assign hex_segB    = seg_b_q;
    assign hex_gridB   = grid_b_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomized bench for sevenseg_scan_driver against a cycle-indexed model:
// the cycle number since reset release determines slot, digit and frame.
module tb_sevenseg_scan_driver;

    localparam int CLK_DIV = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = 4 * CLK_DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  en_in = '0;
    logic        update_req = 1'b0;
    logic        update_ack, frame_start;
    logic [7:0]  hex_segA, hex_segB;
    logic [3:0]  hex_gridA, hex_gridB;
`ifdef SEVENSEG_BRIGHTNESS_EN
    logic [3:0]  brightness = 4'hF;
    logic [3:0]  sh_b;
`endif

    sevenseg_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .update_req (update_req),
`ifdef SEVENSEG_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .update_ack (update_ack),
        .frame_start(frame_start),
        .hex_segA   (hex_segA),
        .hex_gridA  (hex_gridA),
        .hex_segB   (hex_segB),
        .hex_gridB  (hex_gridB)
    );

    always #5 clock = ~clock;

    logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    int          acks;
    logic [31:0] sh_data;
    logic [7:0]  sh_dp, sh_en;
    bit          ld_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        cyc     = 0;
        sh_data = '0;
        sh_dp   = '0;
        sh_en   = '0;
        ld_prev = 1'b0;
`ifdef SEVENSEG_BRIGHTNESS_EN
        sh_b    = '0;
`endif
    endtask

    // Advance one clock and check every output against the model.
    task automatic tick();
        bit         load_now, on;
        int         s, i, w;
        logic [7:0] e_sa, e_sb;
        logic [3:0] e_ga, e_gb;
        load_now = ((cyc % FRAME) == FRAME - 1) && update_req;
        @(posedge clock);
        #1;
        s = cyc % CLK_DIV;
        i = (cyc / CLK_DIV) % 4;
        cyc++;
`ifdef SEVENSEG_BRIGHTNESS_EN
        w = ((CLK_DIV - BLANK) * (int'(sh_b) + 1)) >> 4;
`else
        w = CLK_DIV - BLANK;
`endif
        on   = (s >= BLANK) && (s < BLANK + w);
        e_sa = 8'hFF; e_ga = 4'hF; e_sb = 8'hFF; e_gb = 4'hF;
        if (on && sh_en[i]) begin
            e_ga = ~(4'b0001 << i);
            e_sa = ~{sh_dp[i], glyph[sh_data[4*i +: 4]]};
        end
        if (on && sh_en[i+4]) begin
            e_gb = ~(4'b0001 << i);
            e_sb = ~{sh_dp[i+4], glyph[sh_data[16 + 4*i +: 4]]};
        end
        check("segA", hex_segA, e_sa);
        check("gridA", hex_gridA, e_ga);
        check("segB", hex_segB, e_sb);
        check("gridB", hex_gridB, e_gb);
        check("ack", update_ack, ld_prev);
        check("frame_start", frame_start, ((cyc - 1) % FRAME) == 0);
        check("gridA_onehot", $countones(~hex_gridA) <= 1, 1);
        check("gridB_onehot", $countones(~hex_gridB) <= 1, 1);
        if (update_ack) acks++;
        ld_prev = load_now;
        if (load_now) begin
            sh_data = data_in;
            sh_dp   = dp_in;
            sh_en   = en_in;
`ifdef SEVENSEG_BRIGHTNESS_EN
            sh_b    = brightness;
`endif
        end
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_segA", hex_segA, 8'hFF);
        check("rst_gridB", hex_gridB, 4'hF);
        check("rst_ack", update_ack, 0);
        check("rst_fs", frame_start, 0);
        repeat (ncyc - 1) @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        check("rel_segB", hex_segB, 8'hFF);
        check("rel_gridA", hex_gridA, 4'hF);
        check("rel_ack", update_ack, 0);
        check("rel_fs", frame_start, 0);
    endtask

    task automatic directed_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        data_in    = d;
        dp_in      = dp;
        en_in      = en;
        update_req = 1'b1;
        acks       = 0;
        repeat (2 * FRAME) begin
            tick();
            if (update_ack) update_req = 1'b0;
        end
        check("directed_ack_count", acks, 1);
    endtask

    initial begin
        model_clear();
        do_reset(3);

        // Idle frame: nothing loaded, display stays dark.
        repeat (FRAME) begin
            data_in = $urandom;
            tick();
        end

`ifdef SEVENSEG_BRIGHTNESS_EN
        brightness = 4'hF;
`endif
        directed_load(32'h7654_3210, 8'h00, 8'hFF);
        directed_load(32'h7654_3210, 8'h01, 8'h0F);

`ifdef SEVENSEG_BRIGHTNESS_EN
        brightness = 4'd7;
        directed_load(32'hFEDC_BA98, 8'hA5, 8'hFF);
        brightness = 4'd0;
        directed_load(32'h0123_4567, 8'h00, 8'hFF);
`endif

        // Random inputs and sporadic requests.
        repeat (10 * FRAME) begin
            data_in    = $urandom;
            dp_in      = 8'($urandom);
            en_in      = 8'($urandom);
            update_req = ($urandom_range(0, 5) == 0);
`ifdef SEVENSEG_BRIGHTNESS_EN
            brightness = 4'($urandom);
`endif
            tick();
        end

        // Request held across three frame ends: one ack per frame.
        update_req = 1'b1;
        acks = 0;
        while ((cyc % FRAME) != 0) tick();
        repeat (3 * FRAME + 2) begin
            data_in = $urandom;
            en_in   = 8'($urandom);
            dp_in   = 8'($urandom);
            tick();
        end
        check("held_ack_count", acks, 3);

        // Reset right after a load edge: the pending ack must be dropped.
        while ((cyc % FRAME) != 0) tick();
        do_reset(2);
        update_req = 1'b0;
        repeat (2 * FRAME) begin
            data_in = $urandom;
            tick();
        end

        // Reset in the middle of a slot after a random run.
        repeat (FRAME + 13) begin
            data_in    = $urandom;
            en_in      = 8'($urandom);
            update_req = ($urandom_range(0, 1) == 0);
            tick();
        end
        do_reset(1);
        repeat (2 * FRAME) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
